mpls_pattern_ctrl: RTL and testbench
====================================

MPLS_PATTERN_CTRL -- requirements
Module: mpls_pattern_ctrl

Interface
REQ-001 The block SHALL have these parameters:
  - DEBOUNCE_CYCLES, default 16: stable-input cycles needed to accept a press or a release (minimum 2).
  - DWELL_CYCLES, default 256: cycles between auto-advance steps (minimum 2).
  - INIT_SEL, default 4'd0: pattern_sel value after reset.
REQ-002 The block SHALL have these ports:
  - clk_pll  input  1  single clock; all flops use its rising edge.
  - rstn  input  1  reset, asynchronous, active-low.
  - btn_next  input  1  raw push-button, active-high, asynchronous to clk_pll, bouncing.
  - btn_prev  input  1  raw push-button, same properties as btn_next.
  - auto_en  input  1  auto-cycle request, level-sensitive, synchronous to clk_pll.
  - pattern_sel  output  4  registered pattern selection for the LED pattern generator.
  - sel_strobe  output  1  one-cycle pulse in the first cycle a new pattern_sel value is visible.

Function
REQ-003 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-004 Each button SHALL have an independent debounce FSM with states RELEASED, PRESS_CHK, PRESSED and RELEASE_CHK, plus a counter.
REQ-005 RELEASED SHALL go to PRESS_CHK, with the counter cleared, when the synchronized input is 1.
REQ-006 In PRESS_CHK, a 0 input SHALL return the FSM to RELEASED; otherwise the counter SHALL increment, and on the cycle the counter equals DEBOUNCE_CYCLES-1 the FSM SHALL go to PRESSED.
REQ-007 The transition into PRESSED SHALL assert that button's internal step pulse for exactly one cycle.
REQ-008 PRESSED SHALL go to RELEASE_CHK, with the counter cleared, when the input is 0.
REQ-009 In RELEASE_CHK, a 1 input SHALL return the FSM to PRESSED without a new step pulse; otherwise, after DEBOUNCE_CYCLES consecutive low cycles, the FSM SHALL go to RELEASED.
REQ-010 A held button SHALL produce exactly one step; there is no auto-repeat.
REQ-011 On the clock edge following a step pulse, pattern_sel SHALL update: next adds +1 modulo 16 (15 wraps to 0), prev subtracts 1 modulo 16 (0 wraps to 15).
REQ-012 If next and prev step pulses occur in the same cycle, they SHALL cancel: pattern_sel is unchanged and sel_strobe is not asserted.
REQ-013 sel_strobe SHALL be asserted exactly in the cycles where pattern_sel differs from its previous-cycle value; it is never asserted otherwise.
REQ-014 Latency SHALL be exactly 2 (synchronizer) + DEBOUNCE_CYCLES + 1 clock cycles, measured from the first clk_pll edge that samples a clean high on a button to pattern_sel changing.

Reset
REQ-015 While rstn=0, the block SHALL hold:
  - pattern_sel = INIT_SEL;
  - sel_strobe = 0;
  - both FSMs in RELEASED with counters at 0;
  - synchronizers at 0;
  - dwell counter at 0.
REQ-016 Reset asserted mid-debounce or mid-dwell SHALL discard all progress; no step SHALL be issued after rstn deasserts unless a new full qualification completes.
REQ-017 sel_strobe SHALL NOT pulse on reset release.

Configuration
REQ-018 Macro MPLS_AUTO_CYCLE_EN SHALL compile in the auto-cycle feature.
REQ-019 With MPLS_AUTO_CYCLE_EN defined, the dwell counter SHALL behave as follows:
  - It increments every cycle while auto_en=1.
  - At DWELL_CYCLES-1 it wraps to 0 and issues an auto step (+1 modulo 16), applied with the same timing as REQ-011.
  - It is cleared whenever auto_en=0 or a manual step pulse occurs.
  - A manual step coincident with an auto step SHALL win; the auto step is discarded.
REQ-020 With MPLS_AUTO_CYCLE_EN undefined, the auto_en port SHALL remain present but be ignored, no dwell logic SHALL be synthesized, and pattern_sel SHALL change only via the buttons.

Verification
REQ-021 Bench parameters SHALL be DEBOUNCE_CYCLES=4, DWELL_CYCLES=8, INIT_SEL=0.
REQ-022 The bench SHALL cover these directed scenarios:
  - Clean btn_next held high for 20 cycles -> pattern_sel goes 0 to 1 exactly 7 cycles after the first sampling edge; a single sel_strobe pulse; no further change while held.
  - btn_next bouncing 1,0,1,0 then held stable -> exactly one increment, occurring 7 cycles after the start of the stable run.
  - pattern_sel=15 then a next press -> 0; pattern_sel=0 then a prev press -> 15; sel_strobe pulses once each.
  - Both buttons pressed on the same cycle -> both step pulses coincide; pattern_sel unchanged; sel_strobe stays 0.
  - rstn pulsed low at cycle 3 of PRESS_CHK -> pattern_sel=0, no step after release until a full re-qualification.
  - MPLS_AUTO_CYCLE_EN defined, auto_en=1 -> pattern_sel 0,1,2 at 8-cycle spacing; a manual next on a tick cycle gives a single increment and the dwell restarts. Without the macro: pattern_sel stays 0.

Source files
------------

// File: rtl/mpls_pattern_ctrl.sv
// Debounced next/prev buttons step a 4-bit LED pattern select, 2+DEBOUNCE_CYCLES+1 cycles after a clean press.
// Define MPLS_AUTO_CYCLE_EN to compile in the dwell-timer auto-advance driven by auto_en.

module mpls_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_pll,
  input  logic rstn,
  input  logic btn,
  output logic step
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_t;

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_t     state_q;
  db_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          step_q;
  logic          step_d;

  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign btn_s = sync_q[1];

  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // The step is registered on entry to PRESSED so it is a clean one-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign step = step_q;

endmodule

module mpls_pattern_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         DWELL_CYCLES    = 256,
  parameter logic [3:0] INIT_SEL        = 4'd0
) (
  input  logic       clk_pll,
  input  logic       rstn,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [3:0] pattern_sel,
  output logic       sel_strobe
);

  logic       step_next;
  logic       step_prev;
  logic       manual_step;
  logic       auto_step;
  logic [3:0] sel_q;
  logic [3:0] sel_d;
  logic       strobe_q;

  mpls_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_pll (clk_pll),
    .rstn    (rstn),
    .btn     (btn_next),
    .step    (step_next)
  );

  mpls_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk_pll (clk_pll),
    .rstn    (rstn),
    .btn     (btn_prev),
    .step    (step_prev)
  );

  assign manual_step = step_next | step_prev;

`ifdef MPLS_AUTO_CYCLE_EN
  localparam int DWC = $clog2(DWELL_CYCLES);
  localparam logic [DWC-1:0] DWELL_LAST = DWC'(DWELL_CYCLES - 1);

  logic [DWC-1:0] dwell_q;
  logic           auto_step_q;

  // Any manual step restarts the dwell so the user's choice is held a full period.
  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      dwell_q     <= '0;
      auto_step_q <= 1'b0;
    end else if (!auto_en || manual_step) begin
      dwell_q     <= '0;
      auto_step_q <= 1'b0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_q     <= '0;
      auto_step_q <= 1'b1;
    end else begin
      dwell_q     <= dwell_q + 1'b1;
      auto_step_q <= 1'b0;
    end
  end

  assign auto_step = auto_step_q;
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign auto_step      = 1'b0;
`endif

  // Simultaneous next/prev cancel; any manual activity overrides an auto tick.
  always_comb begin
    sel_d = sel_q;
    case ({step_next, step_prev})
      2'b10:   sel_d = sel_q + 4'd1;
      2'b01:   sel_d = sel_q - 4'd1;
      2'b11:   sel_d = sel_q;
      default: if (auto_step) sel_d = sel_q + 4'd1;
    endcase
  end

  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      sel_q    <= INIT_SEL;
      strobe_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      strobe_q <= (sel_d != sel_q);
    end
  end

  assign pattern_sel = sel_q;
  assign sel_strobe  = strobe_q;

endmodule

// File: tb/tb_mpls_pattern_ctrl.sv
// Directed bench for mpls_pattern_ctrl: expected pattern_sel changes are queued with their due cycle and matched by a monitor.

module tb_mpls_pattern_ctrl;

  logic       clk_pll = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] pattern_sel;
  logic       sel_strobe;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_sel = 4'd0;
  logic [3:0] model = 4'd0;
  int         base;

  typedef struct {
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mpls_pattern_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DWELL_CYCLES    (8),
    .INIT_SEL        (4'd0)
  ) dut (
    .clk_pll     (clk_pll),
    .rstn        (rstn),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .pattern_sel (pattern_sel),
    .sel_strobe  (sel_strobe)
  );

  always #5 clk_pll = ~clk_pll;

  always @(posedge clk_pll) cyc <= cyc + 1;

  // Monitor samples 2 time units after each rising edge.
  always @(posedge clk_pll) begin
    #2;
    if (mon_en && rstn) begin
      total++;
      assert (sel_strobe === (pattern_sel !== prev_sel)) else begin
        bad++;
        $error("FAIL strobe cyc=%0d observed=%b expected=%b", cyc, sel_strobe, (pattern_sel !== prev_sel));
      end
      if (pattern_sel !== prev_sel) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_change cyc=%0d observed=%0d expected=%0d", cyc, pattern_sel, prev_sel);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          total++;
          assert (pattern_sel === mon_e.val) else begin
            bad++;
            $error("FAIL sel_value cyc=%0d observed=%0d expected=%0d", cyc, pattern_sel, mon_e.val);
          end
          total++;
          assert (cyc == mon_e.at) else begin
            bad++;
            $error("FAIL sel_cycle observed=%0d expected=%0d", cyc, mon_e.at);
          end
        end
      end
    end
    prev_sel = pattern_sel;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pll);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic press(input bit nxt);
    if (nxt) btn_next = 1'b1;
    else     btn_prev = 1'b1;
    model = nxt ? model + 4'd1 : model - 4'd1;
    sb.push_back('{model, cyc + 8});
    tick(12);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(12);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_sel", pattern_sel, 4'd0);
    chk("rst_strobe", {3'b000, sel_strobe}, 4'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;
    tick(5);
    chk("post_rst_sel", pattern_sel, 4'd0);

    // Clean press held for 20 cycles
    btn_next = 1'b1;
    model    = 4'd1;
    sb.push_back('{4'd1, cyc + 8});
    tick(20);
    chk("held_sel", pattern_sel, 4'd1);
    btn_next = 1'b0;
    tick(12);

    // Bounce 1,0,1,0 then stable
    btn_next = 1'b1; tick(1);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1;
    model    = 4'd2;
    sb.push_back('{4'd2, cyc + 8});
    tick(12);
    chk("bounce_sel", pattern_sel, 4'd2);
    btn_next = 1'b0;
    tick(12);

    // Walk up to 15, then wrap both ways
    while (model != 4'd15) press(1'b1);
    chk("at_15", pattern_sel, 4'd15);
    press(1'b1);
    chk("wrap_up", pattern_sel, 4'd0);
    press(1'b0);
    chk("wrap_down", pattern_sel, 4'd15);

    // Both buttons on the same cycle cancel
    btn_next = 1'b1;
    btn_prev = 1'b1;
    tick(14);
    chk("both_sel", pattern_sel, 4'd15);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(12);
    chk("both_after", pattern_sel, 4'd15);

    // Reset in the third cycle of PRESS_CHK, button kept held
    btn_next = 1'b1;
    tick(5);
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    chk("midrst_sel", pattern_sel, 4'd0);
    chk("midrst_strobe", {3'b000, sel_strobe}, 4'd0);
    @(negedge clk_pll);
    rstn   = 1'b1;
    mon_en = 1'b1;
    model  = 4'd1;
    sb.push_back('{4'd1, cyc + 8});
    tick(5);
    chk("midrst_no_early", pattern_sel, 4'd0);
    tick(7);
    chk("midrst_requal", pattern_sel, 4'd1);
    btn_next = 1'b0;
    tick(12);

`ifdef MPLS_AUTO_CYCLE_EN
    // Auto-advance, with a manual next landing on a tick cycle
    auto_en = 1'b1;
    base    = cyc;
    sb.push_back('{model + 4'd1, base + 9});
    tick(9);
    btn_next = 1'b1;
    sb.push_back('{model + 4'd2, base + 17});
    sb.push_back('{model + 4'd3, base + 26});
    model = model + 4'd3;
    tick(19);
    auto_en  = 1'b0;
    btn_next = 1'b0;
    tick(12);
    chk("auto_sel", pattern_sel, model);
`else
    // auto_en has no effect without the feature
    auto_en = 1'b1;
    tick(30);
    chk("auto_off_sel", pattern_sel, model);
    auto_en = 1'b0;
    tick(2);
`endif

    tick(5);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL pending_changes observed=%0d expected=0", sb.size());
    end
    chk("final_sel", pattern_sel, model);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
